// File: rtl/tqvp_bus_host.sv
// Initiator for the TinyQV peripheral data bus: one valid/ready request in, one valid/ready response out.
// Optional interrupt latch enabled by defining TQVP_BUS_HOST_IRQ_EN.
module tqvp_bus_host #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready,
  input  logic        user_interrupt,
  output logic        irq_pending,
  input  logic        irq_ack
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] STROBE_IDLE = 2'b11;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  address_q, address_d;
  logic [31:0] data_in_q, data_in_d;
  logic [1:0]  data_write_n_q, data_write_n_d;
  logic [1:0]  data_read_n_q, data_read_n_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0] rdata_masked;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // The read strobe still carries the size code, so it selects the capture mask directly.
  always_comb begin
    case (data_read_n_q)
      2'b00:   rdata_masked = {24'h0, data_out[7:0]};
      2'b01:   rdata_masked = {16'h0, data_out[15:0]};
      default: rdata_masked = data_out;
    endcase
  end

  // NOTE: every signal assigned here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    address_d      = address_q;
    data_in_d      = data_in_q;
    data_write_n_d = data_write_n_q;
    data_read_n_d  = data_read_n_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    cnt_d          = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d       = '0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (req_size == SIZE_ILLEGAL) begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            address_d = req_addr;
            if (req_write) begin
              data_in_d      = req_wdata;
              data_write_n_d = req_size;
              state_d        = S_WRITE;
            end else begin
              data_read_n_d = req_size;
              state_d       = S_READ;
            end
          end
        end
      end

      S_WRITE: begin
        data_write_n_d = STROBE_IDLE;
        state_d        = S_RESP;
      end

      S_READ: begin
        // data_ready is tested before the timeout so a reply on the final allowed cycle succeeds.
        if (data_ready) begin
          rsp_rdata_d   = rdata_masked;
          data_read_n_d = STROBE_IDLE;
          state_d       = S_RESP;
        end else if (TIMEOUT != 0) begin
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            rsp_err_d     = 1'b1;
            rsp_rdata_d   = '0;
            data_read_n_d = STROBE_IDLE;
            state_d       = S_RESP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      address_q      <= '0;
      data_in_q      <= '0;
      data_write_n_q <= STROBE_IDLE;
      data_read_n_q  <= STROBE_IDLE;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      address_q      <= address_d;
      data_in_q      <= data_in_d;
      data_write_n_q <= data_write_n_d;
      data_read_n_q  <= data_read_n_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      cnt_q          <= cnt_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign address      = address_q;
  assign data_in      = data_in_q;
  assign data_write_n = data_write_n_q;
  assign data_read_n  = data_read_n_q;

`ifdef TQVP_BUS_HOST_IRQ_EN
  logic irq_prev_q, irq_prev_d;
  logic irq_pending_q, irq_pending_d;

  // A new edge outranks an acknowledge arriving in the same cycle.
  always_comb begin
    irq_prev_d    = user_interrupt;
    irq_pending_d = irq_pending_q;
    if (irq_ack) begin
      irq_pending_d = 1'b0;
    end
    if (user_interrupt && !irq_prev_q) begin
      irq_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q    <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      irq_prev_q    <= irq_prev_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign irq_pending = irq_pending_q;
`else
  logic unused_irq;
  assign unused_irq  = user_interrupt ^ irq_ack;
  assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_tqvp_bus_host.sv
// Self-checking bench for tqvp_bus_host: directed cases plus randomized transactions
// compared against a transaction-level expectation model.
module tb_tqvp_bus_host;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [5:0]  req_addr = 6'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out = 32'h0;
  logic        data_ready = 1'b0;
  logic        user_interrupt = 1'b0;
  logic        irq_pending;
  logic        irq_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  // Last values the bus should be holding while idle.
  logic [5:0]  last_addr = 6'h0;
  logic [31:0] last_wdata = 32'h0;

  tqvp_bus_host #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt), .irq_pending(irq_pending), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        address !== 6'h0 || data_in !== 32'h0 || data_write_n !== 2'b11 || data_read_n !== 2'b11 ||
        irq_pending !== 1'b0) begin
      failures++;
      $display("FAIL %s: got rdy=%b vld=%b rdata=%h err=%b addr=%h din=%h wn=%b rn=%b irq=%b, expected 1 0 0 0 0 0 11 11 0",
               tag, req_ready, rsp_valid, rsp_rdata, rsp_err, address, data_in, data_write_n, data_read_n, irq_pending);
    end
  endtask

  // Drives one request, plays the peripheral (data_ready after wait_n strobe cycles),
  // holds off the response for hold cycles, and compares everything against the model.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic [5:0] addr,
                         input logic [31:0] wdata, input logic [31:0] dout, input int wait_n,
                         input int hold, input string tag);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat, exp_wr, exp_rd;
    int          wr_cyc, rd_cyc, lat;
    logic        both;
    logic [5:0]  seen_addr;
    logic [31:0] seen_din;
    logic [1:0]  seen_code;

    exp_err = (sz == 2'b11) || (!wr && TIMEOUT != 0 && wait_n >= TIMEOUT);
    exp_rdata = 32'h0;
    if (!wr && !exp_err)
      exp_rdata = (sz == 2'b00) ? (dout & 32'h0000_00FF) : (sz == 2'b01) ? (dout & 32'h0000_FFFF) : dout;
    if (sz == 2'b11) begin
      exp_lat = 1; exp_wr = 0; exp_rd = 0;
    end else if (wr) begin
      exp_lat = 2; exp_wr = 1; exp_rd = 0;
    end else if (exp_err) begin
      exp_lat = 1 + TIMEOUT; exp_wr = 0; exp_rd = TIMEOUT;
    end else begin
      exp_lat = 2 + wait_n; exp_wr = 0; exp_rd = wait_n + 1;
    end

    wr_cyc = 0; rd_cyc = 0; lat = -1; both = 1'b0;
    seen_addr = 6'h0; seen_din = 32'h0; seen_code = 2'b11;

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s req_ready before accept: got %b expected 1", tag, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = addr; req_wdata = wdata;
    data_out = dout;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr = 6'($urandom);

    for (int c = 1; c <= 60; c++) begin
      if (rsp_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (data_write_n !== 2'b11) begin
        wr_cyc++; seen_addr = address; seen_din = data_in; seen_code = data_write_n;
      end
      if (data_read_n !== 2'b11) begin
        rd_cyc++; seen_addr = address; seen_code = data_read_n;
        if (data_write_n !== 2'b11) both = 1'b1;
      end
      data_ready = (data_read_n !== 2'b11) && (rd_cyc - 1 == wait_n);
      @(negedge clk);
    end
    data_ready = 1'b0;

    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s rsp latency: got %0d expected %0d (-1 = none within budget)", tag, lat, exp_lat);
    end
    checks++;
    if (wr_cyc != exp_wr || rd_cyc != exp_rd || both) begin
      failures++;
      $display("FAIL %s strobe cycles: got wr=%0d rd=%0d both=%b expected wr=%0d rd=%0d both=0",
               tag, wr_cyc, rd_cyc, both, exp_wr, exp_rd);
    end
    checks++;
    if (rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
      failures++;
      $display("FAIL %s response: got rdata=%h err=%b expected rdata=%h err=%b",
               tag, rsp_rdata, rsp_err, exp_rdata, exp_err);
    end
    if (sz != 2'b11) begin
      checks++;
      if (seen_code !== sz || seen_addr !== addr || (wr && seen_din !== wdata)) begin
        failures++;
        $display("FAIL %s bus fields: got code=%b addr=%h din=%h expected code=%b addr=%h din=%h",
                 tag, seen_code, seen_addr, seen_din, sz, addr, wr ? wdata : seen_din);
      end
      last_addr = addr;
      if (wr) last_wdata = wdata;
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
        failures++;
        $display("FAIL %s hold %0d: got vld=%b rdy=%b rdata=%h err=%b expected 1 0 %h %b",
                 tag, i, rsp_valid, req_ready, rsp_rdata, rsp_err, exp_rdata, exp_err);
      end
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || address !== last_addr || data_in !== last_wdata ||
        data_write_n !== 2'b11 || data_read_n !== 2'b11) begin
      failures++;
      $display("FAIL %s after consume: got vld=%b rdy=%b addr=%h din=%h wn=%b rn=%b expected 0 1 %h %h 11 11",
               tag, rsp_valid, req_ready, address, data_in, data_write_n, data_read_n, last_addr, last_wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_idle_outputs("reset_asserted");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
    last_addr = 6'h0; last_wdata = 32'h0;
  endtask

  task automatic test_write();
    run_txn(1'b1, 2'b10, 6'h00, 32'h2000_0001, 32'h0, 0, 0, "write32");
    run_txn(1'b1, 2'b00, 6'h3F, 32'hDEAD_BEEF, 32'h0, 0, 0, "write8");
  endtask

  task automatic test_read();
    run_txn(1'b0, 2'b00, 6'h04, 32'h0, 32'hA5A5_1234, 0, 0, "read8_zero_wait");
    run_txn(1'b0, 2'b01, 6'h05, 32'h0, 32'hA5A5_1234, 1, 0, "read16_wait1");
    run_txn(1'b0, 2'b10, 6'h06, 32'h0, 32'hCAFE_F00D, 5, 0, "read32_wait5");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 2'b10, 6'h10, 32'h0, 32'h1234_5678, TIMEOUT - 1, 0, "read_ready_at_limit");
    run_txn(1'b0, 2'b10, 6'h11, 32'h0, 32'h1234_5678, TIMEOUT, 0, "read_timeout");
    run_txn(1'b0, 2'b11, 6'h12, 32'h0, 32'hFFFF_FFFF, 0, 0, "illegal_read");
    run_txn(1'b1, 2'b11, 6'h13, 32'h5555_AAAA, 32'h0, 0, 0, "illegal_write");
  endtask

  task automatic test_backpressure();
    run_txn(1'b0, 2'b01, 6'h20, 32'h0, 32'h0BAD_BEEF, 2, 10, "read_held_10");
    run_txn(1'b1, 2'b10, 6'h21, 32'h0102_0304, 32'h0, 0, 10, "write_held_10");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      logic        wr;
      logic [1:0]  sz;
      int          w;
      wr = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      w = $urandom_range(0, TIMEOUT + 2);
      run_txn(wr, sz, 6'($urandom), $urandom, $urandom, w, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b01; req_addr = 6'h2A;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (data_read_n !== 2'b01) begin
      failures++;
      $display("FAIL mid_read strobe before reset: got %b expected 01", data_read_n);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (data_read_n !== 2'b11 || data_write_n !== 2'b11 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_read async release: got rn=%b wn=%b vld=%b expected 11 11 0",
               data_read_n, data_write_n, rsp_valid);
    end
    @(negedge clk);
    check_idle_outputs("mid_read_in_reset");
    rst_n = 1'b1;
    last_addr = 6'h0; last_wdata = 32'h0;
    run_txn(1'b0, 2'b10, 6'h07, 32'h0, 32'h7777_8888, 0, 0, "read_after_reset");
  endtask

  task automatic test_irq();
`ifdef TQVP_BUS_HOST_IRQ_EN
    @(negedge clk);
    user_interrupt = 1'b1;
    @(negedge clk);
    user_interrupt = 1'b0;
    checks++;
    if (irq_pending !== 1'b1) begin
      failures++;
      $display("FAIL irq_set: got %b expected 1", irq_pending);
    end
    @(negedge clk);
    checks++;
    if (irq_pending !== 1'b1) begin
      failures++;
      $display("FAIL irq_hold: got %b expected 1", irq_pending);
    end
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    checks++;
    if (irq_pending !== 1'b0) begin
      failures++;
      $display("FAIL irq_ack: got %b expected 0", irq_pending);
    end
    user_interrupt = 1'b1;
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    checks++;
    if (irq_pending !== 1'b1) begin
      failures++;
      $display("FAIL irq_edge_with_ack: got %b expected 1", irq_pending);
    end
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    checks++;
    if (irq_pending !== 1'b0) begin
      failures++;
      $display("FAIL irq_level_no_edge: got %b expected 0", irq_pending);
    end
    user_interrupt = 1'b0;
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      user_interrupt = ~user_interrupt;
      irq_ack = 1'(i);
      @(negedge clk);
      checks++;
      if (irq_pending !== 1'b0) begin
        failures++;
        $display("FAIL irq_disabled %0d: got %b expected 0", i, irq_pending);
      end
    end
    user_interrupt = 1'b0;
    irq_ack = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_read();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
